// File: rtl/datamem_axil_slave.sv
// AXI4-Lite slave in front of a small word-addressed data memory.
// Write AW/W are captured independently; reads are single-cycle and independent of writes.
module datamem_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned WI_W   = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              aw_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              w_held;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic              aw_held_n, w_held_n, bvalid_n, rvalid_n;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [STRB_W-1:0] c_strb;
    logic [WI_W-1:0]   c_idx, r_idx;
    logic              c_in_range, r_in_range;

    // Commit uses whichever of address/data is held, else the live channel.
    always_comb begin
        aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs       = S_AXI_WVALID && S_AXI_WREADY;
        ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
        commit     = (aw_held || aw_hs) && (w_held || w_hs);
        c_addr     = aw_held ? aw_addr_q : S_AXI_AWADDR;
        c_data     = w_held ? w_data_q : S_AXI_WDATA;
        c_strb     = w_held ? w_strb_q : S_AXI_WSTRB;
        c_idx      = c_addr[ADDR_W-1:2];
        r_idx      = S_AXI_ARADDR[ADDR_W-1:2];
        c_in_range = 32'(c_idx) < MEM_DEPTH;
        r_in_range = 32'(r_idx) < MEM_DEPTH;
        aw_held_n  = commit ? 1'b0 : (aw_held || aw_hs);
        w_held_n   = commit ? 1'b0 : (w_held || w_hs);
        bvalid_n   = commit ? 1'b1 : (S_AXI_BVALID && !S_AXI_BREADY);
        rvalid_n   = ar_hs ? 1'b1 : (S_AXI_RVALID && !S_AXI_RREADY);
    end

    // Channel state and registered READYs (derived from next-state).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RDATA   <= '0;
        end else begin
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            S_AXI_AWREADY <= !aw_held_n && !bvalid_n;
            S_AXI_WREADY  <= !w_held_n && !bvalid_n;
            S_AXI_ARREADY <= !rvalid_n;
            S_AXI_BVALID  <= bvalid_n;
            S_AXI_RVALID  <= rvalid_n;
            if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) S_AXI_BRESP <= c_in_range ? RESP_OKAY : RESP_SLVERR;
            // Nonblocking read of mem gives read-before-write on a same-edge commit.
            if (ar_hs) begin
                S_AXI_RRESP <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                S_AXI_RDATA <= r_in_range ? mem[r_idx[IDX_W-1:0]] : '0;
            end
        end
    end

    // Byte-strobed memory write on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (c_strb[b]) mem[c_idx[IDX_W-1:0]][b*8 +: 8] <= c_data[b*8 +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_datamem_axil_slave.sv
// Directed bench for datamem_axil_slave: vector table plus hand-written timing/corner sequences.
module tb_datamem_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [7:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    datamem_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(8),
        .MEM_DEPTH(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int n = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_f) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_f)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
        if (!S_AXI_BVALID) check("write_timeout", 32'(S_AXI_BVALID), 32'd1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit fired = 0;
        int n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        while (!fired && n < 20) begin
            fired = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
        if (!S_AXI_RVALID) check("read_timeout", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rs;
    logic [31:0] held_data;

    initial begin
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b101; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

        vecs.push_back('{1'b1, 8'h00, 32'h1, 4'hF, 32'h0, 2'b00, "wr_00"});
        vecs.push_back('{1'b1, 8'h04, 32'h2, 4'hF, 32'h0, 2'b00, "wr_04"});
        vecs.push_back('{1'b1, 8'h08, 32'h3, 4'hF, 32'h0, 2'b00, "wr_08"});
        vecs.push_back('{1'b1, 8'h0C, 32'h4, 4'hF, 32'h0, 2'b00, "wr_0c"});
        vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, 2'b00, "rd_00"});
        vecs.push_back('{1'b0, 8'h04, 32'h0, 4'h0, 32'h2, 2'b00, "rd_04"});
        vecs.push_back('{1'b0, 8'h08, 32'h0, 4'h0, 32'h3, 2'b00, "rd_08"});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h4, 2'b00, "rd_0c"});
        vecs.push_back('{1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 32'h0, 2'b00, "wr_10_full"});
        vecs.push_back('{1'b1, 8'h10, 32'h11223344, 4'h5, 32'h0, 2'b00, "wr_10_strb"});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 4'h0, 32'hAA22CC44, 2'b00, "rd_10_strb"});
        vecs.push_back('{1'b0, 8'h13, 32'h0, 4'h0, 32'hAA22CC44, 2'b00, "rd_13_misalign"});
        vecs.push_back('{1'b1, 8'h3D, 32'h0F0F0F0F, 4'hF, 32'h0, 2'b00, "wr_3d_last"});
        vecs.push_back('{1'b0, 8'h3C, 32'h0, 4'h0, 32'h0F0F0F0F, 2'b00, "rd_3c_last"});
        vecs.push_back('{1'b1, 8'h40, 32'h55, 4'hF, 32'h0, 2'b10, "wr_40_oor"});
        vecs.push_back('{1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 2'b10, "rd_40_oor"});
        vecs.push_back('{1'b0, 8'hFC, 32'h0, 4'h0, 32'h0, 2'b10, "rd_fc_oor"});
        vecs.push_back('{1'b0, 8'h00, 32'h0, 4'h0, 32'h1, 2'b00, "rd_00_after_oor"});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 4'h0, 32'h4, 2'b00, "rd_0c_after_oor"});
        vecs.push_back('{1'b0, 8'h38, 32'h0, 4'h0, 32'h0, 2'b00, "rd_38_untouched"});
        vecs.push_back('{1'b0, 8'h3C, 32'h0, 4'h0, 32'h0F0F0F0F, 2'b00, "rd_3c_after_oor"});

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        ARESET = 1'b0;
        tick();
        check("post_rst_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                check({vecs[i].name, "_bresp"}, 32'(rs), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, rd, rs);
                check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_data);
                check({vecs[i].name, "_rresp"}, 32'(rs), 32'(vecs[i].exp_resp));
            end
        end

        // W first, AW three cycles later; B the cycle after AW
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        check("wfirst_wready_low", 32'(S_AXI_WREADY), 32'd0);
        check("wfirst_awready_high", 32'(S_AXI_AWREADY), 32'd1);
        check("wfirst_no_b", 32'(S_AXI_BVALID), 32'd0);
        tick(); tick();
        check("wfirst_still_no_b", 32'(S_AXI_BVALID), 32'd0);
        S_AXI_AWADDR = 8'h20; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("wfirst_bresp", 32'(S_AXI_BRESP), 32'd0);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        check("wfirst_b_cleared", 32'(S_AXI_BVALID), 32'd0);
        axi_read(8'h20, rd, rs);
        check("wfirst_rdata", rd, 32'hDEADBEEF);

        // Write backpressure with a second write pending
        S_AXI_AWADDR = 8'h28; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        check("bp_same_cycle_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_AWADDR = 8'h2C; S_AXI_WDATA = 32'h22;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_ready_low", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd0);
            check("bp_bvalid_held", 32'(S_AXI_BVALID), 32'd1);
        end
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        check("bp_b_released", 32'(S_AXI_BVALID), 32'd0);
        check("bp_ready_back", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd3);
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bp_second_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
        axi_read(8'h28, rd, rs);
        check("bp_rd_28", rd, 32'h11);
        axi_read(8'h2C, rd, rs);
        check("bp_rd_2c", rd, 32'h22);

        // Read backpressure: RDATA stable while RREADY low
        S_AXI_ARADDR = 8'h08; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        held_data = 32'h3;
        for (int c = 0; c < 5; c++) begin
            check("rbp_rvalid", 32'(S_AXI_RVALID), 32'd1);
            check("rbp_rdata_stable", S_AXI_RDATA, held_data);
            check("rbp_arready_low", 32'(S_AXI_ARREADY), 32'd0);
            S_AXI_ARADDR = 8'h0C;
            tick();
        end
        S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
        check("rbp_released", 32'(S_AXI_RVALID), 32'd0);

        // Read captured at the same edge as a write commit to the same word
        S_AXI_AWADDR = 8'h04; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 8'h04;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("rbw_both_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd3);
        check("rbw_old_data", S_AXI_RDATA, 32'h2);
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        axi_read(8'h04, rd, rs);
        check("rbw_new_data", rd, 32'h99);

        // Reset while both B and R are pending
        S_AXI_AWADDR = 8'h00; S_AXI_WDATA = 32'h77; S_AXI_ARADDR = 8'h00;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        check("prerst_pending", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check("midrst_valids_low", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        tick();
        check("midrst_readys_high", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
        check("midrst_no_stale_b", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
        axi_read(8'h00, rd, rs);
        check("midrst_rd_00", rd, 32'h0);
        check("midrst_rd_00_resp", 32'(rs), 32'd0);
        axi_read(8'h0C, rd, rs);
        check("midrst_rd_0c", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
